vcache_stat_tx: RTL and testbench

VCACHE_STAT_TX -- requirements
Module: vcache_stat_tx

---
 rtl/vcache_stat_pkg.sv | 25 ++
 rtl/vcache_stat_tx_if.sv | 33 +++
 rtl/vcache_stat_ctr.sv | 23 ++
 rtl/vcache_stat_tx.sv | 161 ++++++++++++++++
 tb/tb_vcache_stat_tx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vcache_stat_pkg.sv
// Shared constants and enums for the vcache statistics record transmitter.
// The record is a fixed sequence of words; the index enum names each slot.
package vcache_stat_pkg;

    localparam int unsigned rec_len_lp  = 7;
    localparam int unsigned num_ctr_lp  = 4;

    typedef enum logic [2:0] {
        W_ID      = 3'd0,
        W_CTR     = 3'd1,
        W_TAG     = 3'd2,
        W_LD      = 3'd3,
        W_ST      = 3'd4,
        W_LD_MISS = 3'd5,
        W_ST_MISS = 3'd6
    } word_idx_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam word_idx_e last_idx_lp = word_idx_e'(rec_len_lp - 1);

endpackage

// File: rtl/vcache_stat_tx_if.sv
// Bundle of the cache event inputs and the statistics record stream.
// master drives the cache events and downstream ready; slave is the transmitter.
interface vcache_stat_tx_if #(
    parameter int data_width_p = 32
);
    logic                    v;
    logic                    yumi;
    logic                    miss_v;
    logic                    ld_op;
    logic                    st_op;
    logic [31:0]             global_ctr;
    logic                    print_stat_v;
    logic [data_width_p-1:0] print_stat_tag;
    logic                    stat_v;
    logic [data_width_p-1:0] stat_data;
    logic                    stat_last;
    logic                    stat_ready;
    logic                    busy;
    logic [15:0]             drop_count;

    modport master (
        output v, yumi, miss_v, ld_op, st_op, global_ctr,
               print_stat_v, print_stat_tag, stat_ready,
        input  stat_v, stat_data, stat_last, busy, drop_count
    );

    modport slave (
        input  v, yumi, miss_v, ld_op, st_op, global_ctr,
               print_stat_v, print_stat_tag, stat_ready,
        output stat_v, stat_data, stat_last, busy, drop_count
    );

endinterface

// File: rtl/vcache_stat_ctr.sv
// Wrapping event counter with enable and asynchronous active-low clear.
module vcache_stat_ctr #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_reg <= '0;
        end else if (en_i) begin
            count_reg <= count_reg + width_p'(1);
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/vcache_stat_tx.sv
// Counts accepted cache loads/stores (and their misses) and, on request, streams
// a 7-word snapshot record out over a valid/ready port.
module vcache_stat_tx
    import vcache_stat_pkg::*;
#(
    parameter int          data_width_p  = 32,
    parameter int unsigned instance_id_p = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic                    yumi_i,
    input  logic                    miss_v_i,
    input  logic                    ld_op_i,
    input  logic                    st_op_i,
    input  logic [31:0]             global_ctr_i,
    input  logic                    print_stat_v_i,
    input  logic [data_width_p-1:0] print_stat_tag_i,
    output logic                    stat_v_o,
    output logic [data_width_p-1:0] stat_data_o,
    output logic                    stat_last_o,
    input  logic                    stat_ready_i,
    output logic                    busy_o,
    output logic [15:0]             drop_count_o
);

    logic                    accept;
    logic [num_ctr_lp-1:0]   ctr_en;
    logic [data_width_p-1:0] ctr_val [num_ctr_lp];

    state_e    state_reg, state_next;
    word_idx_e idx_reg, idx_next;

    logic [data_width_p-1:0] snap_ctr_reg;
    logic [data_width_p-1:0] snap_tag_reg;
    logic [data_width_p-1:0] snap_cnt_reg [num_ctr_lp];
    logic [15:0]             drop_reg;

    logic send_hs;
    logic last_hs;
    logic take;
    logic drop;

    // Counter order: ld, st, ld_miss, st_miss (matches record words 3..6).
    assign accept = v_i & yumi_i;
    assign ctr_en = {accept & st_op_i & miss_v_i,
                     accept & ld_op_i & miss_v_i,
                     accept & st_op_i,
                     accept & ld_op_i};

    generate
        for (genvar gi = 0; gi < num_ctr_lp; gi++) begin : g_ctr
            vcache_stat_ctr #(
                .width_p (data_width_p)
            ) u_ctr (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .en_i      (ctr_en[gi]),
                .count_o   (ctr_val[gi])
            );
        end
    endgenerate

    assign send_hs = (state_reg == SEND) & stat_ready_i;
    assign last_hs = send_hs & (idx_reg == last_idx_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            idx_reg   <= W_ID;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // A request is honoured when idle or exactly on the last-word handshake,
    // so back-to-back records run without a bubble.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        take       = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (print_stat_v_i) begin
                    take       = 1'b1;
                    state_next = SEND;
                    idx_next   = W_ID;
                end
            end
            SEND: begin
                if (last_hs) begin
                    idx_next = W_ID;
                    if (print_stat_v_i) begin
                        take       = 1'b1;
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    drop = print_stat_v_i;
                    if (send_hs) begin
                        idx_next = word_idx_e'(idx_reg + 3'd1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = W_ID;
            end
        endcase
    end

    // Counter values sampled here are the pre-increment registered values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            snap_ctr_reg <= '0;
            snap_tag_reg <= '0;
            for (int i = 0; i < num_ctr_lp; i++) begin
                snap_cnt_reg[i] <= '0;
            end
        end else if (take) begin
            snap_ctr_reg <= data_width_p'(global_ctr_i);
            snap_tag_reg <= print_stat_tag_i;
            for (int i = 0; i < num_ctr_lp; i++) begin
                snap_cnt_reg[i] <= ctr_val[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_reg <= '0;
        end else if (drop && (drop_reg != 16'hFFFF)) begin
            drop_reg <= drop_reg + 16'd1;
        end
    end

    always_comb begin
        stat_data_o = '0;
        if (state_reg == SEND) begin
            case (idx_reg)
                W_ID:      stat_data_o = data_width_p'(instance_id_p);
                W_CTR:     stat_data_o = snap_ctr_reg;
                W_TAG:     stat_data_o = snap_tag_reg;
                W_LD:      stat_data_o = snap_cnt_reg[0];
                W_ST:      stat_data_o = snap_cnt_reg[1];
                W_LD_MISS: stat_data_o = snap_cnt_reg[2];
                W_ST_MISS: stat_data_o = snap_cnt_reg[3];
                default:   stat_data_o = '0;
            endcase
        end
    end

    assign busy_o       = (state_reg == SEND);
    assign stat_v_o     = busy_o;
    assign stat_last_o  = stat_v_o & (idx_reg == last_idx_lp);
    assign drop_count_o = drop_reg;

endmodule

// File: tb/tb_vcache_stat_tx.sv
// Random and directed stimulus for vcache_stat_tx, checked every cycle against
// a queue-of-expected-words model of the record stream.
module tb_vcache_stat_tx;

    localparam int          DW   = 32;
    localparam int unsigned INST = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vcache_stat_tx_if #(.data_width_p(DW)) bus ();

    vcache_stat_tx #(
        .data_width_p  (DW),
        .instance_id_p (INST)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .v_i              (bus.v),
        .yumi_i           (bus.yumi),
        .miss_v_i         (bus.miss_v),
        .ld_op_i          (bus.ld_op),
        .st_op_i          (bus.st_op),
        .global_ctr_i     (bus.global_ctr),
        .print_stat_v_i   (bus.print_stat_v),
        .print_stat_tag_i (bus.print_stat_tag),
        .stat_v_o         (bus.stat_v),
        .stat_data_o      (bus.stat_data),
        .stat_last_o      (bus.stat_last),
        .stat_ready_i     (bus.stat_ready),
        .busy_o           (bus.busy),
        .drop_count_o     (bus.drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending record words, event totals, dropped requests.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_cnt [4];
    logic [15:0]   m_drop;
    logic [31:0]   gctr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        m_drop = '0;
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (exp_q.size() != 0);
        check_val("stat_v", 64'(bus.stat_v), 64'(busy));
        check_val("busy", 64'(bus.busy), 64'(busy));
        check_val("stat_data", 64'(bus.stat_data), busy ? 64'(exp_q[0]) : 64'd0);
        check_val("stat_last", 64'(bus.stat_last), 64'(busy && exp_q.size() == 1));
        check_val("drop_count", 64'(bus.drop_count), 64'(m_drop));
    endtask

    task automatic model_edge(input bit v, input bit yumi, input bit miss, input bit ld,
                              input bit st, input bit prt, input logic [DW-1:0] tag,
                              input bit rdy);
        bit busy, hs, last_hs;
        if (!rst_n) return;
        busy    = (exp_q.size() != 0);
        hs      = busy && rdy;
        last_hs = hs && (exp_q.size() == 1);
        if (hs) begin
            $display("t=%0t word %0d data %h last %0b", $time, 7 - exp_q.size(),
                     bus.stat_data, bus.stat_last);
            exp_q.delete(0);
        end
        if (prt) begin
            if (!busy || last_hs) begin
                exp_q.push_back(DW'(INST));
                exp_q.push_back(DW'(gctr));
                exp_q.push_back(tag);
                for (int i = 0; i < 4; i++) exp_q.push_back(m_cnt[i]);
            end else if (m_drop != 16'hFFFF) begin
                m_drop = m_drop + 16'd1;
            end
        end
        if (v && yumi) begin
            if (ld)         m_cnt[0] = m_cnt[0] + 1;
            if (st)         m_cnt[1] = m_cnt[1] + 1;
            if (ld && miss) m_cnt[2] = m_cnt[2] + 1;
            if (st && miss) m_cnt[3] = m_cnt[3] + 1;
        end
    endtask

    task automatic step(input bit v, input bit yumi, input bit miss, input bit ld,
                        input bit st, input bit prt, input logic [DW-1:0] tag,
                        input bit rdy);
        check_outputs();
        bus.v              = v;
        bus.yumi           = yumi;
        bus.miss_v         = miss;
        bus.ld_op          = ld;
        bus.st_op          = st;
        bus.print_stat_v   = prt;
        bus.print_stat_tag = tag;
        bus.stat_ready     = rdy;
        bus.global_ctr     = gctr;
        model_edge(v, yumi, miss, ld, st, prt, tag, rdy);
        @(posedge clk);
        @(negedge clk);
        gctr = gctr + 32'd1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, rdy);
    endtask

    task automatic rand_step(input bit allow_prt);
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             allow_prt && ($urandom_range(0, 9) == 0), DW'($urandom),
             $urandom_range(0, 3) != 0);
    endtask

    // Assert reset between clock edges; outputs must drop without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1, DW'($urandom), 1);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.v = 0; bus.yumi = 0; bus.miss_v = 0; bus.ld_op = 0; bus.st_op = 0;
        bus.print_stat_v = 0; bus.print_stat_tag = '0; bus.stat_ready = 0;
        gctr = $urandom;
        bus.global_ctr = gctr;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // 3 ld (1 miss), 2 st (no miss), a non-accepted op, then a record.
        step(1, 1, 1, 1, 0, 0, '0, 1);
        step(1, 1, 0, 1, 0, 0, '0, 1);
        step(1, 1, 0, 1, 0, 0, '0, 1);
        step(1, 1, 0, 0, 1, 0, '0, 1);
        step(1, 1, 0, 0, 1, 0, '0, 1);
        step(1, 0, 1, 1, 1, 0, '0, 1);
        step(0, 0, 0, 0, 0, 1, DW'(32'hAB), 1);
        check_val("rec_word0", 64'(bus.stat_data), 64'(INST));
        idle(8, 1);

        // Downstream ready toggling every cycle.
        step(0, 0, 0, 0, 0, 1, DW'($urandom), 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, '0, (i % 2) == 0);
        idle(4, 1);

        // Request while at word 3 is dropped; request on last handshake restarts.
        step(0, 0, 0, 0, 0, 1, DW'(32'h11), 1);
        while (exp_q.size() > 4) step(0, 0, 0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, 0, 1, DW'(32'h22), 1);
        check_val("drop_at_word3", 64'(bus.drop_count), 64'd1);
        while (exp_q.size() > 1) step(0, 0, 0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, 0, 1, DW'(32'h33), 1);
        check_val("restart_v", 64'(bus.stat_v), 64'd1);
        check_val("restart_word0", 64'(bus.stat_data), 64'(INST));
        idle(8, 1);

        // ld accept coinciding with the request after 5 loads.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0, '0, 1);
        step(1, 1, 0, 1, 0, 1, DW'(32'h55), 1);
        idle(8, 1);
        step(0, 0, 0, 0, 0, 1, DW'(32'h66), 1);
        idle(8, 1);

        // ld counter wrap from all-ones.
        force dut.g_ctr[0].u_ctr.count_reg = '1;
        #1;
        release dut.g_ctr[0].u_ctr.count_reg;
        m_cnt[0] = '1;
        step(1, 1, 0, 1, 0, 0, '0, 1);
        step(0, 0, 0, 0, 0, 1, DW'(32'h77), 1);
        idle(8, 1);

        // Reset mid-record at word 4; nothing resumes afterwards.
        step(0, 0, 0, 0, 0, 1, DW'(32'h88), 1);
        while (exp_q.size() > 3) step(0, 0, 0, 0, 0, 0, '0, 1);
        do_reset();
        idle(6, 1);

        for (int i = 0; i < 1500; i++) rand_step(1'b1);
        idle(10, 1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
